// File: rtl/freq_sort_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_sort_ctrl_if
// Groups the load-side and drain-side handshakes of the frequency sorter.
//   in_valid / in_ready / in_data       : entry load stream (upstream -> sorter)
//   out_valid / out_ready / out_data    : sorted entry stream (sorter -> tree stage)
//   out_last                            : marks the final entry of a block
//   sort_busy                           : sorter is running transposition passes
// Modports: slave = the sorter, master = the upstream/downstream environment.
// -----------------------------------------------------------------------------
interface freq_sort_ctrl_if #(
   parameter int DSIZE = 18
);
   logic             in_valid;
   logic             in_ready;
   logic [DSIZE-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DSIZE-1:0] out_data;
   logic             out_last;
   logic             sort_busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, sort_busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, sort_busy
   );
endinterface

// File: rtl/freq_sort_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sort_ctrl
// Collects a block of DEPTH {symbol, frequency} entries, sorts them by the low
// OFFSET bits (unsigned, stable) with an odd-even transposition network running
// one pass per cycle, then streams them out smallest key first.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : freq_sort_ctrl_if.slave (load stream, drain stream, out_last,
//            sort_busy)
// -----------------------------------------------------------------------------
module freq_sort_ctrl #(
   parameter int DSIZE  = 18,
   parameter int OFFSET = 8,
   parameter int DEPTH  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   freq_sort_ctrl_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SORT,
      ST_DRAIN
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    idx_q,   idx_d;
   logic [CW-1:0]    pass_q,  pass_d;
   logic [DSIZE-1:0] e_q [DEPTH];
   logic [DSIZE-1:0] e_d [DEPTH];

   // Every output is a pure decode of registered state, so neither in_valid
   // nor out_ready reaches an output combinationally.
   assign bus.in_ready  = (state_q == ST_LOAD);
   assign bus.out_valid = (state_q == ST_DRAIN);
   assign bus.sort_busy = (state_q == ST_SORT);
   assign bus.out_last  = (state_q == ST_DRAIN) && (idx_q == LAST);
   assign bus.out_data  = (state_q == ST_DRAIN) ? e_q[0] : '0;

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      e_d     = e_q;

      unique case (state_q)
         ST_LOAD: begin
            if (bus.in_valid) begin
               e_d[idx_q[AW-1:0]] = bus.in_data;
               if (idx_q == LAST) begin
                  state_d = ST_SORT;
                  idx_d   = '0;
                  pass_d  = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_SORT: begin
            // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)...
            // Pairs in one pass are disjoint, so reading e_q is safe.
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (i[0] == pass_q[0]) begin
                  // Strictly greater: equal keys never move, keeping the sort stable.
                  if (e_q[i][OFFSET-1:0] > e_q[i+1][OFFSET-1:0]) begin
                     e_d[i]   = e_q[i+1];
                     e_d[i+1] = e_q[i];
                  end
               end
            end
            pass_d = pass_q + 1'b1;
            if (pass_q == LAST) begin
               state_d = ST_DRAIN;
               pass_d  = '0;
            end
         end

         ST_DRAIN: begin
            if (bus.out_ready) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  e_d[i] = e_q[i+1];
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
               end
            end
         end

         default: begin
            state_d = ST_LOAD;
            idx_d   = '0;
            pass_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         pass_q  <= '0;
         // NOTE: the entry store is reset too, because out_data must read 0
         // straight out of reset and no stale block may survive an abort.
         for (int i = 0; i < DEPTH; i++) begin
            e_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         for (int i = 0; i < DEPTH; i++) begin
            e_q[i] <= e_d[i];
         end
      end
   end
endmodule

// File: tb/tb_freq_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_sort_ctrl
// Self-checking bench for freq_sort_ctrl. A phase/queue model (insertion-sorted
// reference block) predicts every handshake and output each cycle; directed
// blocks add literal expectations for ordering, stability, latency and reset.
// -----------------------------------------------------------------------------
module tb_freq_sort_ctrl;
   localparam int DSIZE  = 18;
   localparam int OFFSET = 8;
   localparam int DEPTH  = 8;

   typedef logic [DSIZE-1:0] entry_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   freq_sort_ctrl_if #(.DSIZE(DSIZE)) bus ();

   freq_sort_ctrl #(
      .DSIZE (DSIZE),
      .OFFSET(OFFSET),
      .DEPTH (DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic entry_t mk(input int sym, input int key);
      entry_t e;
      e = '0;
      e[DSIZE-1:OFFSET] = (DSIZE-OFFSET)'(sym);
      e[OFFSET-1:0]     = OFFSET'(key);
      return e;
   endfunction

   // ---------------- reference model ----------------
   int     m_phase = 0;        // 0 load, 1 sort, 2 drain
   entry_t m_blk[$];
   entry_t m_sorted[$];
   int     m_sort_cnt = 0;
   int     m_drain = 0;

   entry_t cap[$];
   int     busy_cnt = 0;
   int     cyc = 0;
   int     t_acc = 0;
   int     t_first = 0;
   logic   prev_valid = 1'b0;
   logic   prev_stall = 1'b0;
   entry_t prev_data = '0;

   // Stable insertion sort: a new entry goes after every entry with key <= its own.
   function automatic void ref_sort();
      m_sorted.delete();
      foreach (m_blk[j]) begin
         int pos = 0;
         while (pos < m_sorted.size() &&
                m_sorted[pos][OFFSET-1:0] <= m_blk[j][OFFSET-1:0]) pos++;
         m_sorted.insert(pos, m_blk[j]);
      end
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_phase = 0; m_blk.delete(); m_sort_cnt = 0; m_drain = 0;
         check("rst_in_ready",  32'(bus.in_ready),  1);
         check("rst_out_valid", 32'(bus.out_valid), 0);
         check("rst_out_last",  32'(bus.out_last),  0);
         check("rst_sort_busy", 32'(bus.sort_busy), 0);
         check("rst_out_data",  32'(bus.out_data),  0);
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
         check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
         check("sort_busy", 32'(bus.sort_busy), 32'(m_phase == 1));
         check("out_last",  32'(bus.out_last),  32'(m_phase == 2 && m_drain == DEPTH-1));
         if (m_phase == 2) check("out_data", 32'(bus.out_data), 32'(m_sorted[m_drain]));
         if (prev_stall) check("stall_hold", 32'(bus.out_data), 32'(prev_data));

         if (bus.sort_busy) busy_cnt++;
         if (bus.out_valid && !prev_valid) t_first = cyc;
         if (bus.out_valid && bus.out_ready) cap.push_back(bus.out_data);
         prev_valid = bus.out_valid;
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;

         // advance the model over the upcoming rising edge
         case (m_phase)
            0: if (bus.in_valid) begin
               m_blk.push_back(bus.in_data);
               if (m_blk.size() == DEPTH) begin
                  ref_sort();
                  m_phase = 1; m_sort_cnt = 0; t_acc = cyc;
               end
            end
            1: begin
               m_sort_cnt++;
               if (m_sort_cnt == DEPTH) begin m_phase = 2; m_drain = 0; end
            end
            default: if (bus.out_ready) begin
               m_drain++;
               if (m_drain == DEPTH) begin m_phase = 0; m_blk.delete(); end
            end
         endcase
      end
   end

   // ---------------- drivers ----------------
   task automatic load_block(input entry_t blk[DEPTH], input int gap_pct);
      for (int i = 0; i < DEPTH; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = entry_t'($urandom);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = blk[i];
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready.
   // Garbage is offered on the load port throughout to show it is dropped.
   task automatic drain_block(input int mode);
      bit ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (c % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(1));
         endcase
         bus.in_valid = 1'($urandom_range(1));
         bus.in_data  = entry_t'($urandom);
         @(posedge clk); #1;
         if (cap.size() == DEPTH) begin ok = 1'b1; break; end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("drain_complete", 32'(ok), 1);
   endtask

   task automatic run_block(input entry_t blk[DEPTH], input int gap_pct, input int mode);
      cap.delete();
      busy_cnt = 0;
      load_block(blk, gap_pct);
      drain_block(mode);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      entry_t blk[DEPTH];
      int exp_sym[DEPTH];

      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // descending keys
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, DEPTH - i);
      run_block(blk, 0, 0);
      check("desc_first", 32'(cap[0]), 32'(mk(7, 1)));
      check("desc_last",  32'(cap[DEPTH-1]), 32'(mk(0, 8)));
      check("desc_busy",  32'(busy_cnt), 8);

      // already sorted
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, i + 1);
      run_block(blk, 0, 0);
      for (int i = 0; i < DEPTH; i++) check("asc_order", 32'(cap[i]), 32'(blk[i]));
      check("asc_latency", 32'(t_first - t_acc), 9);

      // all keys equal: stability
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, 5);
      run_block(blk, 30, 1);
      for (int i = 0; i < DEPTH; i++) check("eq_stable", 32'(cap[i]), 32'(mk(i, 5)));

      // 3,3,1,1,... pattern
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, (i % 4 < 2) ? 3 : 1);
      exp_sym = '{2, 3, 6, 7, 0, 1, 4, 5};
      run_block(blk, 0, 1);
      for (int i = 0; i < DEPTH; i++)
         check("dup_stable", 32'(cap[i]), 32'(mk(exp_sym[i], (i < 4) ? 1 : 3)));

      // random blocks with gaps and stalls
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < DEPTH; i++)
            blk[i] = mk(int'($urandom_range(1023)),
                        (b % 2 == 0) ? int'($urandom_range(15)) : int'($urandom_range(255)));
         run_block(blk, 40, (b % 2 == 0) ? 1 : 2);
      end

      // reset during SORT pass 3
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, int'($urandom_range(255)));
      cap.delete();
      load_block(blk, 0);
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_busy", 32'(bus.sort_busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready",  32'(bus.in_ready),  1);
      check("abort_out_valid", 32'(bus.out_valid), 0);
      check("abort_sort_busy", 32'(bus.sort_busy), 0);
      check("abort_out_data",  32'(bus.out_data),  0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_no_output", 32'(cap.size()), 0);
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(DEPTH - 1 - i, int'($urandom_range(255)));
      run_block(blk, 20, 2);

      // extreme keys 255 / 0
      for (int i = 0; i < DEPTH; i++) blk[i] = mk(i, (i % 2 == 0) ? 255 : 0);
      run_block(blk, 0, 0);
      for (int i = 0; i < DEPTH; i++)
         check("extreme_order", 32'(cap[i]),
               32'((i < 4) ? mk(2 * i + 1, 0) : mk(2 * (i - 4), 255)));

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
